// File: rtl/i2c_pkg.sv
// Shared types for the two-master I2C driver arbiter: FSM states,
// driver control/status bundles and the status a non-owner sees.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT0    = 2'd1,
        ST_GNT1    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       ena;
        logic       rw;
        logic       start_transfer;
        logic       stop_transfer;
        logic       r_start;
        logic [7:0] data_wr;
    } drv_ctrl_t;

    typedef struct packed {
        logic       busy;
        logic       ready;
        logic       ack_err;
        logic [7:0] data_rd;
    } drv_stat_t;

    localparam logic       IDLE_BUSY    = 1'b1;
    localparam logic       IDLE_READY   = 1'b0;
    localparam logic       IDLE_ACK_ERR = 1'b0;
    localparam logic [7:0] IDLE_DATA_RD = 8'h00;

    localparam drv_ctrl_t CTRL_OFF = '0;

    localparam drv_stat_t STAT_IDLE = '{
        busy:    IDLE_BUSY,
        ready:   IDLE_READY,
        ack_err: IDLE_ACK_ERR,
        data_rd: IDLE_DATA_RD
    };

endpackage

// File: rtl/i2c_arb_watchdog.sv
// Idle-bus watchdog: counts consecutive cycles with no activity while
// a master holds the grant. clr: activity/no grant; expire: revoke strobe.
module i2c_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // The cycle that reaches LAST is itself an idle cycle, so the
    // strobe marks the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign expire = !clr && (cnt == LAST);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C_Driver between two controllers.
// Ports: m0_*/m1_* master side, drv_* driver side, owner, timeout_err.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       m0_req,
    output logic       m0_gnt,
    input  logic       m0_ena,
    input  logic       m0_rw,
    input  logic       m0_start_transfer,
    input  logic       m0_stop_transfer,
    input  logic       m0_r_start,
    input  logic [7:0] m0_data_wr,
    output logic [7:0] m0_data_rd,
    output logic       m0_busy,
    output logic       m0_ready,
    output logic       m0_ack_err,

    input  logic       m1_req,
    output logic       m1_gnt,
    input  logic       m1_ena,
    input  logic       m1_rw,
    input  logic       m1_start_transfer,
    input  logic       m1_stop_transfer,
    input  logic       m1_r_start,
    input  logic [7:0] m1_data_wr,
    output logic [7:0] m1_data_rd,
    output logic       m1_busy,
    output logic       m1_ready,
    output logic       m1_ack_err,

    output logic       drv_ena,
    output logic       drv_rw,
    output logic       drv_start_transfer,
    output logic       drv_stop_transfer,
    output logic       drv_r_start,
    output logic [7:0] drv_data_wr,
    input  logic [7:0] drv_data_rd,
    input  logic       drv_busy,
    input  logic       drv_ready,
    input  logic       drv_ack_err,

    output logic       owner,
    output logic       timeout_err
);

    arb_state_t state, state_d;
    logic [1:0] lockout;
    logic       to_fire;
    logic       expire;
    logic       wd_clr;
    logic       elig0, elig1;

    drv_ctrl_t  m0_ctrl, m1_ctrl, ctrl_sel;
    drv_stat_t  drv_stat, m0_stat, m1_stat;

    assign m0_ctrl = '{m0_ena, m0_rw, m0_start_transfer,
                       m0_stop_transfer, m0_r_start, m0_data_wr};
    assign m1_ctrl = '{m1_ena, m1_rw, m1_start_transfer,
                       m1_stop_transfer, m1_r_start, m1_data_wr};
    assign drv_stat = '{drv_busy, drv_ready, drv_ack_err, drv_data_rd};

    assign elig0 = m0_req && !lockout[0];
    assign elig1 = m1_req && !lockout[1];

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            owner       <= 1'b1;
            timeout_err <= 1'b0;
            lockout     <= 2'b00;
        end else begin
            state       <= state_d;
            m0_gnt      <= (state_d == ST_GNT0);
            m1_gnt      <= (state_d == ST_GNT1);
            timeout_err <= to_fire;
            if (state == ST_IDLE && state_d == ST_GNT0) owner <= 1'b0;
            if (state == ST_IDLE && state_d == ST_GNT1) owner <= 1'b1;
            // A revoke only happens while the owner still requests,
            // so set and clear never collide.
            lockout[0] <= m0_req &&
                          (lockout[0] || (to_fire && state == ST_GNT0));
            lockout[1] <= m1_req &&
                          (lockout[1] || (to_fire && state == ST_GNT1));
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        to_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                unique case (1'b1)
                    (elig0 && elig1): state_d = owner ? ST_GNT0 : ST_GNT1;
                    (elig0 && !elig1): state_d = ST_GNT0;
                    (!elig0 && elig1): state_d = ST_GNT1;
                    default:           state_d = ST_IDLE;
                endcase
            end
            ST_GNT0: begin
                if (!m0_req) begin
                    state_d = ST_RELEASE;
                end else if (expire) begin
                    state_d = ST_RELEASE;
                    to_fire = 1'b1;
                end
            end
            ST_GNT1: begin
                if (!m1_req) begin
                    state_d = ST_RELEASE;
                end else if (expire) begin
                    state_d = ST_RELEASE;
                    to_fire = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!drv_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output muxing
    always_comb begin
        ctrl_sel = CTRL_OFF;
        m0_stat  = STAT_IDLE;
        m1_stat  = STAT_IDLE;
        unique case (state)
            ST_GNT0: begin
                ctrl_sel = m0_ctrl;
                m0_stat  = drv_stat;
            end
            ST_GNT1: begin
                ctrl_sel = m1_ctrl;
                m1_stat  = drv_stat;
            end
            default: begin
                ctrl_sel = CTRL_OFF;
            end
        endcase
    end

    assign drv_ena            = ctrl_sel.ena;
    assign drv_rw             = ctrl_sel.rw;
    assign drv_start_transfer = ctrl_sel.start_transfer;
    assign drv_stop_transfer  = ctrl_sel.stop_transfer;
    assign drv_r_start        = ctrl_sel.r_start;
    assign drv_data_wr        = ctrl_sel.data_wr;

    assign m0_busy    = m0_stat.busy;
    assign m0_ready   = m0_stat.ready;
    assign m0_ack_err = m0_stat.ack_err;
    assign m0_data_rd = m0_stat.data_rd;
    assign m1_busy    = m1_stat.busy;
    assign m1_ready   = m1_stat.ready;
    assign m1_ack_err = m1_stat.ack_err;
    assign m1_data_rd = m1_stat.data_rd;

    // Outside a grant, or with the owner enabling or the driver busy,
    // the bus is considered in use.
    assign wd_clr = !(state == ST_GNT0 || state == ST_GNT1) ||
                    ctrl_sel.ena || drv_busy;

    i2c_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .expire(expire)
    );

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level ownership model.
module tb_i2c_bus_arbiter;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_ena, m0_rw, m0_st, m0_sp, m0_rs;
    logic       m1_req, m1_ena, m1_rw, m1_st, m1_sp, m1_rs;
    logic [7:0] m0_dw, m1_dw, m0_dr, m1_dr;
    logic       m0_gnt, m0_busy, m0_ready, m0_ack;
    logic       m1_gnt, m1_busy, m1_ready, m1_ack;
    logic       drv_ena, drv_rw, drv_st, drv_sp, drv_rs;
    logic [7:0] drv_dw, drv_dr;
    logic       drv_busy, drv_ready, drv_ack;
    logic       owner, timeout_err;

    int compared   = 0;
    int mismatched = 0;

    // Model: mode 0 = bus free, 1 = held by 'holder', 2 = draining
    int mode, holder, last, idle_run;
    bit lk[2];
    bit to_p;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(T), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_ena(m0_ena),
        .m0_rw(m0_rw), .m0_start_transfer(m0_st),
        .m0_stop_transfer(m0_sp), .m0_r_start(m0_rs),
        .m0_data_wr(m0_dw), .m0_data_rd(m0_dr), .m0_busy(m0_busy),
        .m0_ready(m0_ready), .m0_ack_err(m0_ack),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_ena(m1_ena),
        .m1_rw(m1_rw), .m1_start_transfer(m1_st),
        .m1_stop_transfer(m1_sp), .m1_r_start(m1_rs),
        .m1_data_wr(m1_dw), .m1_data_rd(m1_dr), .m1_busy(m1_busy),
        .m1_ready(m1_ready), .m1_ack_err(m1_ack),
        .drv_ena(drv_ena), .drv_rw(drv_rw),
        .drv_start_transfer(drv_st), .drv_stop_transfer(drv_sp),
        .drv_r_start(drv_rs), .drv_data_wr(drv_dw),
        .drv_data_rd(drv_dr), .drv_busy(drv_busy),
        .drv_ready(drv_ready), .drv_ack_err(drv_ack),
        .owner(owner), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mode = 0; holder = 0; last = 1; idle_run = 0;
        lk[0] = 0; lk[1] = 0; to_p = 0;
    endfunction

    task automatic model_step();
        bit req[2];
        bit ena[2];
        int pick;
        req[0] = m0_req; req[1] = m1_req;
        ena[0] = m0_ena; ena[1] = m1_ena;
        to_p = 0;
        case (mode)
            0: begin
                pick = -1;
                if (req[0] && !lk[0] && req[1] && !lk[1]) pick = 1 - last;
                else if (req[0] && !lk[0]) pick = 0;
                else if (req[1] && !lk[1]) pick = 1;
                if (pick >= 0) begin
                    mode = 1; holder = pick; last = pick; idle_run = 0;
                end
            end
            1: begin
                if (!req[holder]) mode = 2;
                else if (!ena[holder] && !drv_busy) begin
                    idle_run++;
                    if (idle_run == T) begin
                        mode = 2; to_p = 1; lk[holder] = 1;
                    end
                end else idle_run = 0;
            end
            default: if (!drv_busy) mode = 0;
        endcase
        for (int i = 0; i < 2; i++) if (!req[i]) lk[i] = 0;
    endtask

    task automatic check_all();
        bit own0, own1;
        logic [12:0] c_exp;
        logic [10:0] s_drv, s_idle;
        own0 = (mode == 1 && holder == 0);
        own1 = (mode == 1 && holder == 1);
        c_exp = own0 ? {m0_ena, m0_rw, m0_st, m0_sp, m0_rs, m0_dw} :
                own1 ? {m1_ena, m1_rw, m1_st, m1_sp, m1_rs, m1_dw} : '0;
        s_drv  = {drv_busy, drv_ready, drv_ack, drv_dr};
        s_idle = {1'b1, 1'b0, 1'b0, 8'h00};
        check("m0_gnt", m0_gnt, own0);
        check("m1_gnt", m1_gnt, own1);
        check("owner", owner, last[0]);
        check("timeout_err", timeout_err, to_p);
        check("drv_ctrl", {drv_ena, drv_rw, drv_st, drv_sp, drv_rs, drv_dw},
              c_exp);
        check("m0_stat", {m0_busy, m0_ready, m0_ack, m0_dr},
              own0 ? s_drv : s_idle);
        check("m1_stat", {m1_busy, m1_ready, m1_ack, m1_dr},
              own1 ? s_drv : s_idle);
    endtask

    task automatic tick();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int who;
        rst_n = 0;
        {m0_req, m0_ena, m0_rw, m0_st, m0_sp, m0_rs} = '0;
        {m1_req, m1_ena, m1_rw, m1_st, m1_sp, m1_rs} = '0;
        m0_dw = 8'h00; m1_dw = 8'h00;
        drv_dr = 8'h3C; drv_busy = 0; drv_ready = 1; drv_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_owner", owner, 1'b1);
        rst_n = 1;
        tick();

        // Single requester
        m0_req = 1; m0_dw = 8'hA5;
        tick();
        check("tp1_gnt", m0_gnt, 1'b1);
        check("tp1_owner", owner, 1'b0);
        check("tp1_m1_busy", m1_busy, 1'b1);
        check("tp1_data_wr", drv_dw, 8'hA5);
        m0_req = 0;
        repeat (2) tick();

        // Simultaneous requests after reset: m0 first, then m1
        rst_n = 0; tick(); rst_n = 1; tick();
        m0_req = 1; m1_req = 1;
        tick();
        check("tp2_m0_first", m0_gnt, 1'b1);
        m0_req = 0;
        repeat (3) tick();
        check("tp2_m1_next", m1_gnt, 1'b1);
        check("tp2_owner", owner, 1'b1);
        m1_req = 0;
        repeat (2) tick();

        // Continuous contention, 10-cycle transactions, alternating
        m0_req = 1; m1_req = 1; m0_ena = 1; m1_ena = 1;
        for (int r = 0; r < 4; r++) begin
            who = -1;
            for (int k = 0; k < 5 && who < 0; k++) begin
                tick();
                if (m0_gnt) who = 0;
                else if (m1_gnt) who = 1;
            end
            check("tp3_alternate", who, r % 2);
            repeat (9) tick();
            if (who == 0) m0_req = 0; else m1_req = 0;
            tick();
            m0_req = 1; m1_req = 1;
        end
        m0_req = 0; m1_req = 0; m0_ena = 0; m1_ena = 0;
        repeat (3) tick();

        // Owner drops req while driver still busy
        m1_req = 1;
        tick();
        check("tp4_m1_gnt", m1_gnt, 1'b1);
        m1_req = 0; m0_req = 1; drv_busy = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("tp4_no_gnt", m0_gnt, 1'b0);
        end
        check("tp4_drv_off", drv_ena, 1'b0);
        drv_busy = 0;
        repeat (2) tick();
        check("tp4_m0_gnt", m0_gnt, 1'b1);
        m0_req = 0;
        repeat (2) tick();

        // Watchdog revoke and lockout
        m0_req = 1;
        tick();
        for (int k = 0; k < T - 1; k++) begin
            tick();
            check("tp5_hold", m0_gnt, 1'b1);
        end
        tick();
        check("tp5_timeout", timeout_err, 1'b1);
        check("tp5_revoked", m0_gnt, 1'b0);
        repeat (5) tick();
        check("tp5_locked", m0_gnt, 1'b0);
        m0_req = 0;
        tick();
        m0_req = 1;
        repeat (2) tick();
        check("tp5_regrant", m0_gnt, 1'b1);
        m0_req = 0;
        repeat (2) tick();

        // Asynchronous reset while m1 owns the driver
        m1_req = 1; m1_ena = 1;
        tick();
        check("tp6_pre", drv_ena, 1'b1);
        #2 rst_n = 0;
        #1;
        check("tp6_gnt", m1_gnt, 1'b0);
        check("tp6_drv_ena", drv_ena, 1'b0);
        check("tp6_owner", owner, 1'b1);
        model_reset();
        tick();
        rst_n = 1; m1_req = 0; m1_ena = 0;
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) m0_req = ~m0_req;
            if ($urandom_range(7) == 0) m1_req = ~m1_req;
            m0_ena = ($urandom_range(3) == 0);
            m1_ena = ($urandom_range(3) == 0);
            {m0_rw, m0_st, m0_sp, m0_rs} = 4'($urandom);
            {m1_rw, m1_st, m1_sp, m1_rs} = 4'($urandom);
            m0_dw = 8'($urandom); m1_dw = 8'($urandom);
            drv_dr = 8'($urandom);
            drv_busy  = ($urandom_range(4) == 0);
            drv_ready = 1'($urandom);
            drv_ack   = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C_Driver instance between two I2C controllers (m0 = Altimeter_Controller, m1 = IMU_Controller), so both sensors can sit on a single SDA/SCL pair.
- Arbitration is round-robin at transaction granularity: a master owns the driver from grant until it drops its request and the driver goes idle.
- A watchdog reclaims the bus from a master that holds the grant but does nothing.

Parameters:
- TIMEOUT_CYCLES, 50000: consecutive idle cycles a granted master may hold the bus (1 ms at 50 MHz).
- TO_W, 16: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_req  in  1  level request for the bus; held for the whole transaction
- m0_gnt  out  1  registered grant
- m0_ena, m0_rw, m0_start_transfer, m0_stop_transfer, m0_r_start  in  1 each  driver controls
- m0_data_wr  in  8  write byte
- m0_data_rd  out  8  read byte
- m0_busy, m0_ready, m0_ack_err  out  1 each  driver status as seen by m0
- m1_*  same set as m0_*, for master 1
- drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start  out  1 each  to I2C_Driver
- drv_data_wr  out  8  to I2C_Driver
- drv_data_rd  in  8  from I2C_Driver
- drv_busy, drv_ready, drv_ack_err  in  1 each  from I2C_Driver
- owner  out  1  index of the current/last granted master
- timeout_err  out  1  one-cycle pulse on a watchdog revoke

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all state to IDLE; m0_gnt=m1_gnt=0; owner=1 (so m0 wins the first tie); timeout_err=0; watchdog counter=0; lockout flags=0; all drv_* outputs=0.
- States:
  - IDLE: arbitrate among masters whose req=1 and lockout=0. A single requester is granted. If both request, grant ~owner. Next state is GNT0 or GNT1; gnt and owner are registered. Grant latency is 1 cycle after req is sampled.
  - GNT0 / GNT1: the owner's control inputs pass combinationally to drv_*, and drv_* status/data pass back to the owner.
    - If the owner's req=0, go to RELEASE.
    - If the watchdog expires, go to RELEASE, pulse timeout_err, and set lockout[owner]=1.
  - RELEASE: gnt=0 and all drv_* controls forced to 0. Stay until drv_busy=0, then go to IDLE. Minimum dwell is 1 cycle, so back-to-back grants have at least 2 cycles between them.
- Non-owner (or any master in IDLE/RELEASE) sees busy=1, ready=0, ack_err=0, data_rd=8'h00.
- Watchdog:
  - Counter clears in IDLE/RELEASE, and in GNTx whenever owner ena=1 or drv_busy=1.
  - Otherwise it increments.
  - At count == TIMEOUT_CYCLES-1 it revokes the grant. The counter saturates and never wraps.
- Lockout: lockout[i] clears when mi_req=0. A timed-out master must drop req for at least 1 cycle before it can be granted again.
- Simultaneous events:
  - Owner drops req in the same cycle the watchdog expires: req drop wins; no timeout_err.
  - New request arriving in RELEASE: held pending; arbitrated in IDLE.
- Masters must keep req high until their stop_transfer has been accepted. Dropping req mid-transfer still waits for drv_busy=0 in RELEASE; the arbiter never cuts the driver off.
- Reset mid-transaction: asynchronous return to the reset values. The driver is reset by the same rst.

Decomposition:
- Shared package i2c_pkg: state encoding (IDLE, GNT0, GNT1, RELEASE) and the IDLE status constants (busy=1, ready=0, data_rd=8'h00).
- One natural sub-module: i2c_arb_watchdog, holding the counter, clear/saturate logic and the expire strobe.
- Muxing and FSM stay in the top.

Test Plan:
- Reset, then m0_req=1 only → m0_gnt=1 one cycle later, owner=0. m1 sees busy=1. drv_data_wr follows m0_data_wr=8'hA5.
- m0 and m1 assert req in the same cycle after reset → m0 granted. m0 drops req with drv_busy=0 → RELEASE 1 cycle, IDLE, then m1_gnt=1 with owner=1.
- Both requesting continuously, each transaction 10 cycles → grants alternate m0, m1, m0, m1. Never two consecutive grants to one master while the other waits.
- m1 drops req while drv_busy=1 for 20 more cycles → drv_* controls=0, no new grant until drv_busy falls, m0 granted 2 cycles later.
- TIMEOUT_CYCLES=8: m0 granted, ena=0, drv_busy=0 → timeout_err pulses after 8 idle cycles and gnt drops. m0 still holding req is not regranted; after m0 drops req for 1 cycle and reasserts it, m0 is granted.
- rst_n low mid-GNT1 → m1_gnt=0 and drv_ena=0 immediately (asynchronous), owner=1.
